// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared opcode, FSM state and sizing definitions for the ALU arbiter
package alu_pkg;

    localparam int DATA_W = 32;
    localparam int NPORT  = 2;

    typedef enum logic [2:0] {
        OP_ADD  = 3'd0,
        OP_SUB  = 3'd1,
        OP_AND  = 3'd2,
        OP_OR   = 3'd3,
        OP_XOR  = 3'd4,
        OP_MULL = 3'd5,
        OP_MULH = 3'd6,
        OP_INV  = 3'd7
    } alu_op_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        EXEC  = 2'd1,
        EXEC2 = 2'd2,
        RESP  = 2'd3
    } arb_state_e;

    // Multiply opcodes are the only ones that may take the extra EXEC2 cycle
    function automatic logic is_mul(input logic [2:0] op);
        return (op == OP_MULL) || (op == OP_MULH);
    endfunction

endpackage

// File: rtl/alu.sv
// rtl/alu.sv - combinational 32-bit ALU with wrapping add/sub/mul and signed mul-high
module alu
    import alu_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [2:0]        op,
    output logic [DATA_W-1:0] result
);

    // Full signed product; the low half equals the unsigned wrapped product too
    logic [2*DATA_W-1:0] prod;
    assign prod = {{DATA_W{a[DATA_W-1]}}, a} * {{DATA_W{b[DATA_W-1]}}, b};

    // Opcode decode; the invalid opcode falls through to zero
    always_comb begin
        result = '0;
        case (op)
            OP_ADD:  result = a + b;
            OP_SUB:  result = a - b;
            OP_AND:  result = a & b;
            OP_OR:   result = a | b;
            OP_XOR:  result = a ^ b;
            OP_MULL: result = prod[DATA_W-1:0];
            OP_MULH: result = prod[2*DATA_W-1:DATA_W];
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - two-port round-robin front end to one shared ALU (option: ALU_MUL_2CYCLE_EN)
module alu_arbiter
    import alu_pkg::*;
(
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NPORT-1:0]              req_valid,
    output logic [NPORT-1:0]              req_ready,
    input  logic [NPORT-1:0][DATA_W-1:0]  req_a,
    input  logic [NPORT-1:0][DATA_W-1:0]  req_b,
    input  logic [NPORT-1:0][2:0]         req_op,
    output logic [NPORT-1:0]              rsp_valid,
    input  logic [NPORT-1:0]              rsp_ready,
    output logic [DATA_W-1:0]             rsp_result,
    output logic                          rsp_sf,
    output logic                          rsp_zf
);

    arb_state_e          state_q;
    arb_state_e          state_d;
    logic                last_grant;
    logic                grant_port;
    logic                port_q;
    logic [DATA_W-1:0]   a_q;
    logic [DATA_W-1:0]   b_q;
    logic [2:0]          op_q;
    logic [DATA_W-1:0]   alu_result;
    logic                accept;

`ifdef ALU_MUL_2CYCLE_EN
    logic [DATA_W-1:0]   mul_q;
`endif

    alu u_alu (
        .a      (a_q),
        .b      (b_q),
        .op     (op_q),
        .result (alu_result)
    );

    // Round-robin pick: on a tie the port not granted last wins
    always_comb begin
        grant_port = 1'b0;
        if (req_valid == 2'b11) begin
            grant_port = ~last_grant;
        end else if (req_valid[1]) begin
            grant_port = 1'b1;
        end
    end

    assign accept = (state_q == IDLE) && (|req_valid) && !rst;

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state plus the per-port handshake outputs
    always_comb begin
        state_d   = state_q;
        req_ready = '0;
        rsp_valid = '0;
        case (state_q)
            IDLE: begin
                if (|req_valid) begin
                    req_ready[grant_port] = 1'b1;
                    state_d               = EXEC;
                end
            end
            EXEC: begin
`ifdef ALU_MUL_2CYCLE_EN
                state_d = is_mul(op_q) ? EXEC2 : RESP;
`else
                state_d = RESP;
`endif
            end
            EXEC2: begin
`ifdef ALU_MUL_2CYCLE_EN
                state_d = RESP;
`else
                state_d = IDLE;
`endif
            end
            RESP: begin
                rsp_valid[port_q] = 1'b1;
                if (rsp_ready[port_q]) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (rst) begin
            state_d   = IDLE;
            req_ready = '0;
            rsp_valid = '0;
        end
    end

    // Capture the granted request and remember who won for the next tie
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant <= 1'b1;
            port_q     <= 1'b0;
            a_q        <= '0;
            b_q        <= '0;
            op_q       <= '0;
        end else if (accept) begin
            last_grant <= grant_port;
            port_q     <= grant_port;
            a_q        <= req_a[grant_port];
            b_q        <= req_b[grant_port];
            op_q       <= req_op[grant_port];
        end
    end

    // Output registers, written once per operation and held through RESP
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_result <= '0;
            rsp_sf     <= 1'b0;
            rsp_zf     <= 1'b0;
`ifdef ALU_MUL_2CYCLE_EN
            mul_q      <= '0;
`endif
        end else begin
`ifdef ALU_MUL_2CYCLE_EN
            if (state_q == EXEC && is_mul(op_q)) begin
                mul_q <= alu_result;
            end else if (state_q == EXEC) begin
                rsp_result <= alu_result;
                rsp_sf     <= alu_result[DATA_W-1];
                rsp_zf     <= (alu_result == '0);
            end else if (state_q == EXEC2) begin
                rsp_result <= mul_q;
                rsp_sf     <= mul_q[DATA_W-1];
                rsp_zf     <= (mul_q == '0);
            end
`else
            if (state_q == EXEC) begin
                rsp_result <= alu_result;
                rsp_sf     <= alu_result[DATA_W-1];
                rsp_zf     <= (alu_result == '0);
            end
`endif
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - directed table-driven bench for alu_arbiter (honours ALU_MUL_2CYCLE_EN)
module tb_alu_arbiter;

    logic              clk;
    logic              rst;
    logic [1:0]        req_valid;
    logic [1:0]        req_ready;
    logic [1:0][31:0]  req_a;
    logic [1:0][31:0]  req_b;
    logic [1:0][2:0]   req_op;
    logic [1:0]        rsp_valid;
    logic [1:0]        rsp_ready;
    logic [31:0]       rsp_result;
    logic              rsp_sf;
    logic              rsp_zf;

    int n_cmp = 0;
    int n_bad = 0;

    alu_arbiter dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_op     (req_op),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_result (rsp_result),
        .rsp_sf     (rsp_sf),
        .rsp_zf     (rsp_zf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          port;
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  op;
        logic [31:0] res;
        logic        sf;
        logic        zf;
    } vec_t;

    vec_t vecs[13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic int exp_lat(input logic [2:0] op);
`ifdef ALU_MUL_2CYCLE_EN
        if (op == 3'd5 || op == 3'd6) return 3;
`endif
        return 2;
    endfunction

    // Wait (bounded) at negedges until rsp_valid appears; returns cycles since accept cycle
    task automatic wait_rsp(output int lat);
        lat = 1;
        @(negedge clk);
        while (rsp_valid == 2'b00 && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        lat++;
        if (rsp_valid == 2'b00) lat = 99;
    endtask

    task automatic consume(input int port);
        rsp_ready[port] = 1'b1;
        @(negedge clk);
        rsp_ready = '0;
        chk("rsp_valid_after_consume", {30'd0, rsp_valid}, 32'd0);
    endtask

    // One complete operation on one port; inputs are scrambled after accept
    task automatic do_op(input string name, input vec_t v);
        int lat;
        req_valid = '0;
        req_valid[v.port] = 1'b1;
        req_a[v.port] = v.a;
        req_b[v.port] = v.b;
        req_op[v.port] = v.op;
        #1;
        chk({name, "_req_ready"}, {30'd0, req_ready}, 32'd1 << v.port);
        lat = 1;
        @(negedge clk);
        req_valid = '0;
        req_a = {32'hDEADBEEF, 32'hCAFEF00D};
        req_b = {32'h12345678, 32'h9ABCDEF0};
        req_op = {3'd4, 3'd3};
        while (rsp_valid == 2'b00 && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        chk({name, "_latency"}, lat, exp_lat(v.op));
        chk({name, "_rsp_valid"}, {30'd0, rsp_valid}, 32'd1 << v.port);
        chk({name, "_result"}, rsp_result, v.res);
        chk({name, "_sf"}, {31'd0, rsp_sf}, {31'd0, v.sf});
        chk({name, "_zf"}, {31'd0, rsp_zf}, {31'd0, v.zf});
        consume(v.port);
    endtask

    initial begin
        int lat;
        logic [31:0] held;
        vecs[0]  = '{0, 32'd5,          32'd3,          3'd0, 32'd8,          1'b0, 1'b0};
        vecs[1]  = '{1, 32'd3,          32'd5,          3'd1, 32'hFFFFFFFE,   1'b1, 1'b0};
        vecs[2]  = '{0, 32'hF0,         32'h0F,         3'd2, 32'd0,          1'b0, 1'b1};
        vecs[3]  = '{1, 32'hF0,         32'h0F,         3'd3, 32'hFF,         1'b0, 1'b0};
        vecs[4]  = '{0, 32'hFF00FF00,   32'h0F0F0F0F,   3'd4, 32'hF00FF00F,   1'b1, 1'b0};
        vecs[5]  = '{1, 32'h00010000,   32'h00010000,   3'd5, 32'd0,          1'b0, 1'b1};
        vecs[6]  = '{0, 32'd7,          32'd6,          3'd5, 32'd42,         1'b0, 1'b0};
        vecs[7]  = '{1, 32'hFFFFFFFF,   32'd2,          3'd6, 32'hFFFFFFFF,   1'b1, 1'b0};
        vecs[8]  = '{0, 32'h7FFFFFFF,   32'd1,          3'd0, 32'h80000000,   1'b1, 1'b0};
        vecs[9]  = '{1, 32'h1234,       32'h5678,       3'd7, 32'd0,          1'b0, 1'b1};
        vecs[10] = '{0, 32'h40000000,   32'd4,          3'd6, 32'd1,          1'b0, 1'b0};
        vecs[11] = '{1, 32'h80000000,   32'h80000000,   3'd6, 32'h40000000,   1'b0, 1'b0};
        vecs[12] = '{0, 32'd0,          32'd1,          3'd1, 32'hFFFFFFFF,   1'b1, 1'b0};

        rst = 1'b1;
        req_valid = 2'b11;
        req_a = '0;
        req_b = '0;
        req_op = '0;
        rsp_ready = 2'b11;
        @(negedge clk);
        chk("reset_req_ready", {30'd0, req_ready}, 32'd0);
        chk("reset_rsp_valid", {30'd0, rsp_valid}, 32'd0);
        chk("reset_result", rsp_result, 32'd0);
        chk("reset_flags", {30'd0, rsp_sf, rsp_zf}, 32'd0);
        @(negedge clk);
        req_valid = '0;
        rsp_ready = '0;
        rst = 1'b0;

        // Tie after reset: port0 first, then port1
        req_valid = 2'b11;
        req_a = {32'hF0, 32'd3};
        req_b = {32'h0F, 32'd5};
        req_op = {3'd2, 3'd1};
        #1;
        chk("tie_first_grant", {30'd0, req_ready}, 32'd1);
        @(negedge clk);
        req_valid = 2'b10;
        while (rsp_valid == 2'b00 && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        chk("tie_p0_rsp_valid", {30'd0, rsp_valid}, 32'd1);
        chk("tie_p0_result", rsp_result, 32'hFFFFFFFE);
        chk("tie_p0_sf", {31'd0, rsp_sf}, 32'd1);
        chk("tie_p0_req_ready_in_resp", {30'd0, req_ready}, 32'd0);
        rsp_ready = 2'b01;
        @(negedge clk);
        rsp_ready = '0;
        chk("tie_second_grant", {30'd0, req_ready}, 32'd2);
        @(negedge clk);
        req_valid = '0;
        lat = 0;
        while (rsp_valid == 2'b00 && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        chk("tie_p1_rsp_valid", {30'd0, rsp_valid}, 32'd2);
        chk("tie_p1_result", rsp_result, 32'd0);
        chk("tie_p1_zf", {31'd0, rsp_zf}, 32'd1);
        consume(1);

        for (int i = 0; i < 13; i++) begin
            do_op($sformatf("vec%0d", i), vecs[i]);
        end

        // Backpressure on port1 with a stray rsp_ready on port0 and a pending port0 request
        req_valid = 2'b10;
        req_a[1] = 32'h11111111;
        req_b[1] = 32'h22222222;
        req_op[1] = 3'd0;
        @(negedge clk);
        req_valid = '0;
        wait_rsp(lat);
        chk("bp_rsp_valid_initial", {30'd0, rsp_valid}, 32'd2);
        held = 32'h33333333;
        req_valid = 2'b01;
        for (int c = 0; c < 4; c++) begin
            rsp_ready = (c == 1) ? 2'b01 : 2'b00;
            #1;
            chk($sformatf("bp_req_ready_c%0d", c), {30'd0, req_ready}, 32'd0);
            @(negedge clk);
            chk($sformatf("bp_rsp_valid_c%0d", c), {30'd0, rsp_valid}, 32'd2);
            chk($sformatf("bp_result_c%0d", c), rsp_result, held);
        end
        req_valid = '0;
        rsp_ready = '0;
        consume(1);

        // Reset in EXEC: first make port0 the last grant so the post-reset tie is meaningful
        req_valid = 2'b01;
        req_a[0] = 32'd9;
        req_b[0] = 32'd9;
        req_op[0] = 3'd0;
        @(negedge clk);
        req_valid = '0;
        wait_rsp(lat);
        consume(0);
        req_valid = 2'b01;
        req_op[0] = 3'd3;
        req_a[0] = 32'hA5A5A5A5;
        req_b[0] = 32'h0;
        @(negedge clk);
        req_valid = 2'b11;
        rst = 1'b1;
        rsp_ready = 2'b11;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk($sformatf("rst_exec_rsp_valid_c%0d", c), {30'd0, rsp_valid}, 32'd0);
            chk($sformatf("rst_exec_req_ready_c%0d", c), {30'd0, req_ready}, 32'd0);
            chk($sformatf("rst_exec_outputs_c%0d", c), rsp_result | {30'd0, rsp_sf, rsp_zf}, 32'd0);
        end
        rst = 1'b0;
        rsp_ready = '0;
        req_op = {3'd0, 3'd0};
        req_a = {32'd100, 32'd1};
        req_b = {32'd200, 32'd2};
        #1;
        chk("rst_exec_tie_grant", {30'd0, req_ready}, 32'd1);
        @(negedge clk);
        req_valid = '0;
        wait_rsp(lat);
        chk("rst_exec_after_result", rsp_result, 32'd3);
        chk("rst_exec_after_no_stale", {30'd0, rsp_valid}, 32'd1);
        consume(0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation exceeded time bound");
        $fatal(1);
    end

endmodule
